// File: rtl/wr_dma.sv
// wr_dma: Avalon-ST sink to Avalon-MM write-master DMA with a CSR slave and a decoupling FIFO.
// Optional build macro WR_DMA_BYTEENABLE_EN derives eop-beat byteenables from ast_sink_empty_i.
module wr_dma #(
  parameter int AMM_DMA_DATA_W   = 64,
  parameter int AMM_DMA_ADDR_W   = 32,
  parameter int AMM_CSR_DATA_W   = 32,
  parameter int AMM_CSR_ADDR_W   = 4,
  parameter int AST_SINK_SYMBOLS = AMM_DMA_DATA_W / 8,
  parameter int AST_SINK_EMPTY_W = (AST_SINK_SYMBOLS == 1) ? 1 : $clog2(AST_SINK_SYMBOLS),
  parameter int FIFO_ADDR_W      = 6
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  input  logic [AMM_CSR_ADDR_W-1:0]   amm_slave_csr_address_i,
  input  logic                        amm_slave_csr_read_i,
  output logic [AMM_CSR_DATA_W-1:0]   amm_slave_csr_readdata_o,
  input  logic                        amm_slave_csr_write_i,
  input  logic [AMM_CSR_DATA_W-1:0]   amm_slave_csr_writedata_i,
  output logic [AMM_DMA_ADDR_W-1:0]   amm_dma_address_o,
  output logic                        amm_dma_write_o,
  output logic [AMM_DMA_DATA_W-1:0]   amm_dma_writedata_o,
  output logic [AST_SINK_SYMBOLS-1:0] amm_dma_byteenable_o,
  input  logic                        amm_dma_waitrequest_i,
  input  logic [AMM_DMA_DATA_W-1:0]   ast_sink_data_i,
  input  logic                        ast_sink_valid_i,
  output logic                        ast_sink_ready_o,
  input  logic [AST_SINK_EMPTY_W-1:0] ast_sink_empty_i,
  input  logic                        ast_sink_startofpacket_i,
  input  logic                        ast_sink_endofpacket_i,
  output logic                        end_irq_o
);
  localparam int DEPTH  = 1 << FIFO_ADDR_W;
  localparam int FIFO_W = AMM_DMA_DATA_W + AST_SINK_SYMBOLS;
  localparam logic [FIFO_ADDR_W:0] READY_LIMIT = (FIFO_ADDR_W + 1)'(DEPTH - 4);
  localparam logic [AMM_CSR_ADDR_W-1:0] CSR_BASE   = AMM_CSR_ADDR_W'(0);
  localparam logic [AMM_CSR_ADDR_W-1:0] CSR_SIZE   = AMM_CSR_ADDR_W'(1);
  localparam logic [AMM_CSR_ADDR_W-1:0] CSR_RUN    = AMM_CSR_ADDR_W'(2);
  localparam logic [AMM_CSR_ADDR_W-1:0] CSR_STATUS = AMM_CSR_ADDR_W'(3);
  localparam logic [AMM_CSR_ADDR_W-1:0] CSR_WRCNT  = AMM_CSR_ADDR_W'(4);

  typedef enum logic [1:0] {IDLE = 2'd0, RECV = 2'd1, DRAIN = 2'd2, FLUSH = 2'd3} state_t;

  state_t                      state;
  logic [AMM_CSR_DATA_W-1:0]   base_addr;
  logic [AMM_CSR_DATA_W-1:0]   size;
  logic [AMM_CSR_DATA_W-1:0]   wr_cnt;
  logic [AMM_CSR_DATA_W:0]     beat_cnt;
  logic                        done;
  logic                        overflow;
  logic                        busy;
  logic                        run_req;
  logic [FIFO_W-1:0]           mem [DEPTH];
  logic [FIFO_ADDR_W-1:0]      wr_ptr;
  logic [FIFO_ADDR_W-1:0]      rd_ptr;
  logic [FIFO_ADDR_W:0]        usedw;
  logic [FIFO_W-1:0]           head;
  logic                        has_data;
  logic                        accept;
  logic                        push;
  logic                        pop;
  logic [AST_SINK_SYMBOLS-1:0] beat_be;
  logic                        unused_inputs;

`ifdef WR_DMA_BYTEENABLE_EN
  assign beat_be = ast_sink_endofpacket_i ? ({AST_SINK_SYMBOLS{1'b1}} << ast_sink_empty_i)
                                          : {AST_SINK_SYMBOLS{1'b1}};
  assign unused_inputs = ast_sink_startofpacket_i;
`else
  assign beat_be = {AST_SINK_SYMBOLS{1'b1}};
  assign unused_inputs = ^{ast_sink_startofpacket_i, ast_sink_empty_i};
`endif

  assign busy     = (state != IDLE);
  assign run_req  = amm_slave_csr_write_i && (amm_slave_csr_address_i == CSR_RUN) &&
                    amm_slave_csr_writedata_i[0];
  assign has_data = (usedw != {(FIFO_ADDR_W + 1){1'b0}});
  assign ast_sink_ready_o = ((state == RECV) || (state == DRAIN)) && (usedw < READY_LIMIT);
  assign accept   = ast_sink_valid_i && ast_sink_ready_o;
  assign push     = accept && (state == RECV);
  assign pop      = has_data && !amm_dma_waitrequest_i;

  // Show-ahead head entry; outputs are forced to zero whenever the FIFO is empty.
  assign head                 = mem[rd_ptr];
  assign amm_dma_write_o      = has_data;
  assign amm_dma_writedata_o  = has_data ? head[FIFO_W-1:AST_SINK_SYMBOLS] : {AMM_DMA_DATA_W{1'b0}};
  assign amm_dma_byteenable_o = has_data ? head[AST_SINK_SYMBOLS-1:0] : {AST_SINK_SYMBOLS{1'b0}};

  // FIFO storage; no reset needed since usedw gates every read.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= {ast_sink_data_i, beat_be};
  end

  // FIFO pointers and occupancy; a simultaneous push and pop leaves usedw unchanged.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr <= {FIFO_ADDR_W{1'b0}};
      rd_ptr <= {FIFO_ADDR_W{1'b0}};
      usedw  <= {(FIFO_ADDR_W + 1){1'b0}};
    end else begin
      if (push) wr_ptr <= wr_ptr + FIFO_ADDR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + FIFO_ADDR_W'(1);
      case ({push, pop})
        2'b10:   usedw <= usedw + (FIFO_ADDR_W + 1)'(1);
        2'b01:   usedw <= usedw - (FIFO_ADDR_W + 1)'(1);
        default: usedw <= usedw;
      endcase
    end
  end

  // CSR configuration registers and registered read port.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      base_addr                <= {AMM_CSR_DATA_W{1'b0}};
      size                     <= {AMM_CSR_DATA_W{1'b0}};
      amm_slave_csr_readdata_o <= {AMM_CSR_DATA_W{1'b0}};
    end else begin
      if (amm_slave_csr_write_i && (amm_slave_csr_address_i == CSR_BASE))
        base_addr <= amm_slave_csr_writedata_i;
      if (amm_slave_csr_write_i && (amm_slave_csr_address_i == CSR_SIZE))
        size <= amm_slave_csr_writedata_i;
      if (amm_slave_csr_read_i) begin
        case (amm_slave_csr_address_i)
          CSR_BASE:   amm_slave_csr_readdata_o <= base_addr;
          CSR_SIZE:   amm_slave_csr_readdata_o <= size;
          CSR_STATUS: amm_slave_csr_readdata_o <= AMM_CSR_DATA_W'({overflow, busy, done});
          CSR_WRCNT:  amm_slave_csr_readdata_o <= wr_cnt;
          default:    amm_slave_csr_readdata_o <= {AMM_CSR_DATA_W{1'b0}};
        endcase
      end
    end
  end

  // Run-control FSM with write address, counters and status flags.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state             <= IDLE;
      amm_dma_address_o <= {AMM_DMA_ADDR_W{1'b0}};
      wr_cnt            <= {AMM_CSR_DATA_W{1'b0}};
      beat_cnt          <= {(AMM_CSR_DATA_W + 1){1'b0}};
      done              <= 1'b0;
      overflow          <= 1'b0;
      end_irq_o         <= 1'b0;
    end else begin
      end_irq_o <= 1'b0;
      if (pop) begin
        amm_dma_address_o <= amm_dma_address_o + AMM_DMA_ADDR_W'(1);
        wr_cnt            <= wr_cnt + AMM_CSR_DATA_W'(1);
      end
      case (state)
        IDLE: begin
          if (run_req) begin
            state             <= RECV;
            amm_dma_address_o <= AMM_DMA_ADDR_W'(base_addr);
            wr_cnt            <= {AMM_CSR_DATA_W{1'b0}};
            beat_cnt          <= {(AMM_CSR_DATA_W + 1){1'b0}};
            done              <= 1'b0;
            overflow          <= 1'b0;
          end
        end
        RECV: begin
          if (accept) begin
            beat_cnt <= beat_cnt + (AMM_CSR_DATA_W + 1)'(1);
            // beat_cnt counts earlier beats, so equality marks beat number SIZE+1
            if (ast_sink_endofpacket_i) begin
              state <= FLUSH;
            end else if (beat_cnt == {1'b0, size}) begin
              state    <= DRAIN;
              overflow <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (accept && ast_sink_endofpacket_i) state <= FLUSH;
        end
        FLUSH: begin
          if (!has_data) begin
            state     <= IDLE;
            done      <= 1'b1;
            end_irq_o <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wr_dma.sv
// Randomized self-checking bench for wr_dma against a packet-level model of memory writes.
module tb_wr_dma;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [3:0]  csr_addr;
  logic        csr_read, csr_write;
  logic [31:0] csr_wdata, csr_rdata;
  logic [31:0] dma_addr;
  logic        dma_write;
  logic [63:0] dma_wdata;
  logic [7:0]  dma_be;
  logic        wait_req;
  logic [63:0] sink_data;
  logic        sink_valid, sink_ready, sink_sop, sink_eop;
  logic [2:0]  sink_empty;
  logic        end_irq;

`ifdef WR_DMA_BYTEENABLE_EN
  localparam bit BE_EN = 1'b1;
`else
  localparam bit BE_EN = 1'b0;
`endif

  int vectors = 0;
  int miscompares = 0;
  int wr_prob = 0;
  int gap_prob = 0;
  bit hold_wr = 1'b0;
  int irq_cnt = 0;
  logic [31:0] wa[$];
  logic [63:0] wd[$];
  logic [7:0]  wb[$];
  logic [63:0] sent[$];
  logic [31:0] ea[$];
  logic [63:0] ed[$];
  logic [7:0]  eb[$];

  wr_dma dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .amm_slave_csr_address_i(csr_addr), .amm_slave_csr_read_i(csr_read),
    .amm_slave_csr_readdata_o(csr_rdata), .amm_slave_csr_write_i(csr_write),
    .amm_slave_csr_writedata_i(csr_wdata),
    .amm_dma_address_o(dma_addr), .amm_dma_write_o(dma_write),
    .amm_dma_writedata_o(dma_wdata), .amm_dma_byteenable_o(dma_be),
    .amm_dma_waitrequest_i(wait_req),
    .ast_sink_data_i(sink_data), .ast_sink_valid_i(sink_valid), .ast_sink_ready_o(sink_ready),
    .ast_sink_empty_i(sink_empty), .ast_sink_startofpacket_i(sink_sop),
    .ast_sink_endofpacket_i(sink_eop), .end_irq_o(end_irq)
  );

  // Memory slave stall generator
  initial begin
    wait_req = 1'b0;
    forever begin
      @(posedge clk); #1;
      wait_req = hold_wr ? 1'b1 : (int'($urandom_range(0, 99)) < wr_prob);
    end
  end

  // Memory slave: records completed writes, checks stalled writes stay stable, counts irq pulses
  initial begin
    bit held = 1'b0;
    bit irq_prev = 1'b0;
    logic [31:0] ha;
    logic [63:0] hd;
    logic [7:0]  hb;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held = 1'b0;
        irq_prev = 1'b0;
      end else begin
        if (held) begin
          vectors++;
          if (!(dma_write === 1'b1 && dma_addr === ha && dma_wdata === hd && dma_be === hb)) begin
            miscompares++;
            $display("FAIL hold_stable: got w=%b a=%h d=%h be=%h, required w=1 a=%h d=%h be=%h",
                     dma_write, dma_addr, dma_wdata, dma_be, ha, hd, hb);
          end
        end
        held = 1'b0;
        if (dma_write === 1'b1 && wait_req === 1'b0) begin
          wa.push_back(dma_addr); wd.push_back(dma_wdata); wb.push_back(dma_be);
        end else if (dma_write === 1'b1) begin
          held = 1'b1; ha = dma_addr; hd = dma_wdata; hb = dma_be;
        end
        if (end_irq === 1'b1) begin
          irq_cnt++;
          vectors++;
          if (irq_prev) begin
            miscompares++;
            $display("FAIL irq_width: got end_irq high 2 cycles, required 1");
          end
        end
        irq_prev = (end_irq === 1'b1);
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic csr_wr(input logic [3:0] a, input logic [31:0] d);
    csr_addr = a; csr_wdata = d; csr_write = 1'b1;
    @(posedge clk); #1;
    csr_write = 1'b0;
  endtask

  task automatic csr_rd(input logic [3:0] a, output logic [31:0] d);
    csr_addr = a; csr_read = 1'b1;
    @(posedge clk); #1;
    csr_read = 1'b0;
    d = csr_rdata;
  endtask

  task automatic send_beats(input int n, input bit eop_last, input int empty);
    for (int i = 0; i < n; i++) begin
      int waited;
      int gaps;
      logic [63:0] d;
      waited = 0; gaps = 0;
      d = {$urandom, $urandom};
      while (int'($urandom_range(0, 99)) < gap_prob && gaps < 8) begin
        @(posedge clk); #1; gaps++;
      end
      sink_valid = 1'b1; sink_data = d; sink_sop = (i == 0);
      sink_eop   = eop_last && (i == n - 1);
      sink_empty = sink_eop ? 3'(empty) : 3'($urandom_range(0, 7));
      do begin @(negedge clk); waited++; end while (sink_ready !== 1'b1 && waited < 2000);
      if (sink_ready !== 1'b1) begin
        vectors++; miscompares++;
        $display("FAIL sink_accept: got ready=%b after %0d cycles, required 1", sink_ready, waited);
        sink_valid = 1'b0; sink_eop = 1'b0;
        return;
      end
      @(posedge clk); #1;
      sent.push_back(d);
      sink_valid = 1'b0; sink_eop = 1'b0; sink_sop = 1'b0;
    end
  endtask

  task automatic start_run(input logic [31:0] base, input logic [31:0] size);
    csr_wr(4'd0, base);
    csr_wr(4'd1, size);
    wa.delete(); wd.delete(); wb.delete(); sent.delete();
    csr_wr(4'd2, 32'd1);
  endtask

  task automatic wait_done(input string name, output logic [31:0] st);
    int n;
    n = 0;
    do begin csr_rd(4'd3, st); n++; end while (st[0] !== 1'b1 && n < 3000);
    if (st[0] !== 1'b1) begin
      vectors++; miscompares++;
      $display("FAIL %s done_timeout: got STATUS=%h, required done bit set", name, st);
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  // Reference: the first min(beats, SIZE+1) accepted beats land at BASE, BASE+1, ...
  function automatic void build_expect(input logic [31:0] base, input logic [31:0] size,
                                       input int n, input int empty);
    longint lim;
    logic [7:0] be;
    lim = longint'(size) + 1;
    ea.delete(); ed.delete(); eb.delete();
    for (int i = 0; i < n && longint'(i) < lim; i++) begin
      be = 8'hFF;
      if (BE_EN && i == n - 1)
        for (int k = 0; k < empty; k++) be[k] = 1'b0;
      ea.push_back(base + 32'(i)); ed.push_back(sent[i]); eb.push_back(be);
    end
  endfunction

  task automatic test_reset();
    logic [31:0] r;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({sink_ready, dma_write, dma_addr, dma_be, dma_wdata, csr_rdata, end_irq} !== 139'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got ready=%b write=%b addr=%h be=%h data=%h rd=%h irq=%b, required all 0",
               sink_ready, dma_write, dma_addr, dma_be, dma_wdata, csr_rdata, end_irq);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    csr_rd(4'd3, r);
    vectors++;
    if (r !== 32'd0) begin miscompares++; $display("FAIL reset_status: got %h, required 0", r); end
    csr_rd(4'd4, r);
    vectors++;
    if (r !== 32'd0) begin miscompares++; $display("FAIL reset_wrcnt: got %h, required 0", r); end
  endtask

  task automatic test_run(input string name, input logic [31:0] base, input logic [31:0] size,
                          input int n, input int empty, input int prob);
    logic [31:0] st, r, exp_st;
    int irq0;
    wr_prob = prob;
    irq0 = irq_cnt;
    start_run(base, size);
    send_beats(n, 1'b1, empty);
    wait_done(name, st);
    build_expect(base, size, n, empty);
    exp_st = (longint'(n) > longint'(size) + 1) ? 32'h5 : 32'h1;
    vectors++;
    if (wa.size() != ea.size()) begin
      miscompares++;
      $display("FAIL %s write_count: got %0d, required %0d", name, wa.size(), ea.size());
    end
    foreach (ea[i]) begin
      vectors++;
      if (i >= wa.size() || wa[i] !== ea[i] || wd[i] !== ed[i] || wb[i] !== eb[i]) begin
        miscompares++;
        $display("FAIL %s write[%0d]: got a=%h d=%h be=%h, required a=%h d=%h be=%h",
                 name, i, wa[i], wd[i], wb[i], ea[i], ed[i], eb[i]);
      end
    end
    vectors++;
    if (st !== exp_st) begin miscompares++; $display("FAIL %s status: got %h, required %h", name, st, exp_st); end
    csr_rd(4'd4, r);
    vectors++;
    if (r !== 32'(ea.size())) begin
      miscompares++; $display("FAIL %s wr_cnt: got %0d, required %0d", name, r, ea.size());
    end
    vectors++;
    if (irq_cnt - irq0 != 1) begin
      miscompares++; $display("FAIL %s irq_count: got %0d, required 1", name, irq_cnt - irq0);
    end
  endtask

  task automatic test_basic();
    test_run("basic", 32'h100, 32'd3, 4, 0, 0);
  endtask

  task automatic test_waitrequest();
    gap_prob = 30;
    test_run("waitreq50", 32'h100, 32'd3, 4, 0, 50);
    gap_prob = 0;
  endtask

  task automatic test_overflow();
    test_run("overflow", 32'h100, 32'd1, 5, 0, 30);
  endtask

  task automatic test_empty();
    test_run("empty3", 32'h100, 32'd7, 2, 3, 0);
    vectors++;
    if (wb.size() != 2 || wb[1] !== (BE_EN ? 8'hF8 : 8'hFF)) begin
      miscompares++;
      $display("FAIL empty3 last_be: got %h, required %h", wb[1], BE_EN ? 8'hF8 : 8'hFF);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] st;
    wr_prob = 0; gap_prob = 0;
    hold_wr = 1'b1;
    start_run(32'h100, 32'd63);
    fork
      send_beats(64, 1'b1, 0);
      begin
        repeat (100) @(posedge clk);
        #1;
        vectors++;
        if (sent.size() != 60 || sink_ready !== 1'b0 || wa.size() != 0 ||
            dma_write !== 1'b1 || dma_addr !== 32'h100) begin
          miscompares++;
          $display("FAIL backpressure_hold: got accepted=%0d ready=%b writes=%0d write=%b addr=%h, required 60/0/0/1/100",
                   sent.size(), sink_ready, wa.size(), dma_write, dma_addr);
        end
        hold_wr = 1'b0;
      end
    join
    wait_done("backpressure", st);
    build_expect(32'h100, 32'd63, 64, 0);
    vectors++;
    if (wa.size() != 64) begin
      miscompares++; $display("FAIL backpressure write_count: got %0d, required 64", wa.size());
    end
    foreach (ea[i]) begin
      vectors++;
      if (i >= wa.size() || wa[i] !== ea[i] || wd[i] !== ed[i]) begin
        miscompares++;
        $display("FAIL backpressure write[%0d]: got a=%h d=%h, required a=%h d=%h", i, wa[i], wd[i], ea[i], ed[i]);
      end
    end
  endtask

  task automatic test_reset_midrun();
    logic [31:0] st, r;
    wr_prob = 0; gap_prob = 0;
    hold_wr = 1'b1;
    start_run(32'h300, 32'd15);
    send_beats(5, 1'b0, 0);
    rst_n = 1'b0;
    #1;
    vectors++;
    if (dma_write !== 1'b0 || sink_ready !== 1'b0 || dma_addr !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_midrun outputs: got write=%b ready=%b addr=%h, required 0/0/0", dma_write, sink_ready, dma_addr);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    hold_wr = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    csr_rd(4'd3, r);
    vectors++;
    if (wa.size() != 0 || dma_write !== 1'b0 || r !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_midrun idle: got writes=%0d write=%b status=%h, required 0/0/0", wa.size(), dma_write, r);
    end
    start_run(32'h200, 32'd3);
    send_beats(2, 1'b0, 0);
    csr_wr(4'd2, 32'd1);
    send_beats(2, 1'b1, 0);
    wait_done("rerun", st);
    build_expect(32'h200, 32'd3, 4, 0);
    vectors++;
    if (wa.size() != 4) begin miscompares++; $display("FAIL rerun write_count: got %0d, required 4", wa.size()); end
    foreach (ea[i]) begin
      vectors++;
      if (i >= wa.size() || wa[i] !== ea[i] || wd[i] !== ed[i]) begin
        miscompares++;
        $display("FAIL rerun write[%0d]: got a=%h d=%h, required a=%h d=%h", i, wa[i], wd[i], ea[i], ed[i]);
      end
    end
    csr_rd(4'd4, r);
    vectors++;
    if (r !== 32'd4) begin miscompares++; $display("FAIL rerun wr_cnt: got %0d, required 4", r); end
  endtask

  task automatic test_random();
    gap_prob = 20;
    test_run("size_max_wrap", 32'hFFFF_FFFE, 32'hFFFF_FFFF, 4, 5, 25);
    for (int t = 0; t < 6; t++) begin
      gap_prob = int'($urandom_range(0, 40));
      test_run("random", {$urandom} & 32'hFFFF_FFF0, 32'($urandom_range(0, 9)),
               int'($urandom_range(1, 12)), int'($urandom_range(0, 7)), int'($urandom_range(0, 70)));
    end
    gap_prob = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    csr_addr = 4'd0; csr_read = 1'b0; csr_write = 1'b0; csr_wdata = 32'd0;
    sink_data = 64'd0; sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0; sink_empty = 3'd0;
    test_reset();
    test_basic();
    test_waitrequest();
    test_overflow();
    test_empty();
    test_backpressure();
    test_reset_midrun();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
